// File: rtl/cv32e40p_ecc_err_monitor.sv
// rtl/cv32e40p_ecc_err_monitor.sv - register-file ECC error monitor: per-channel SEC counters, DED sticky flags, health FSM
// Optional first-DED capture port enabled by CV32E40P_ECC_MON_FIRST_ERR_EN.
module cv32e40p_ecc_err_monitor #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 8,
    parameter int SEC_THRESH = 16,
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] sec_i,
    input  logic [NUM_CH-1:0] ded_i,
    input  logic [IDX_W-1:0]  rd_ch_i,
    output logic [CNT_W:0]    rd_data_o,
    input  logic              clr_ch_valid_i,
    input  logic [IDX_W-1:0]  clr_ch_i,
    input  logic              clr_all_i,
`ifdef CV32E40P_ECC_MON_FIRST_ERR_EN
    output logic [IDX_W-1:0]  first_ded_ch_o,
    output logic              first_ded_vld_o,
`endif
    output logic              degraded_o,
    output logic              fatal_o,
    output logic              irq_o,
    output logic              ded_any_o
);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_DEG   = 2'd1,
        ST_FATAL = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SEC_THRESH);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [CNT_W:0]    rd_data_q, rd_data_d;
    state_e            state_q, state_d, state_base;
    logic              irq_q, irq_d;
    logic              any_ge_d;

    // Clear is applied first so a same-cycle event on that channel wins.
    always_comb begin
        any_ge_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]    = cnt_q[c];
            sticky_d[c] = sticky_q[c];
            if (clr_all_i || (clr_ch_valid_i && (clr_ch_i == IDX_W'(c)))) begin
                cnt_d[c]    = '0;
                sticky_d[c] = 1'b0;
            end
            if (sec_i[c] && (cnt_d[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_d[c] + 1'b1;
            end
            if (ded_i[c]) begin
                sticky_d[c] = 1'b1;
            end
            if (cnt_d[c] >= THRESH) begin
                any_ge_d = 1'b1;
            end
        end
        rd_data_d = '0;
        if (int'(rd_ch_i) < NUM_CH) begin
            rd_data_d = {sticky_d[rd_ch_i], cnt_d[rd_ch_i]};
        end
    end

    // clr_all_i restarts evaluation from OK, so a coincident DED still raises one irq.
    always_comb begin
        state_base = clr_all_i ? ST_OK : state_q;
        state_d    = state_base;
        case (state_base)
            ST_OK: begin
                if (|sticky_d)    state_d = ST_FATAL;
                else if (any_ge_d) state_d = ST_DEG;
            end
            ST_DEG: begin
                if (|sticky_d)     state_d = ST_FATAL;
                else if (!any_ge_d) state_d = ST_OK;
            end
            ST_FATAL: state_d = ST_FATAL;
            default:  state_d = ST_OK;
        endcase
        irq_d = (state_d > state_base);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            sticky_q  <= '0;
            rd_data_q <= '0;
            state_q   <= ST_OK;
            irq_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
            sticky_q  <= sticky_d;
            rd_data_q <= rd_data_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign degraded_o = (state_q == ST_DEG);
    assign fatal_o    = (state_q == ST_FATAL);
    assign irq_o      = irq_q;
    assign ded_any_o  = |sticky_q;

`ifdef CV32E40P_ECC_MON_FIRST_ERR_EN
    logic [IDX_W-1:0] first_ch_q, first_ch_d, low_ch;
    logic             first_vld_q, first_vld_d;

    always_comb begin
        low_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ded_i[c]) low_ch = IDX_W'(c);
        end
        first_ch_d  = clr_all_i ? '0   : first_ch_q;
        first_vld_d = clr_all_i ? 1'b0 : first_vld_q;
        if (!first_vld_d && (|ded_i)) begin
            first_ch_d  = low_ch;
            first_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_ch_q  <= '0;
            first_vld_q <= 1'b0;
        end else begin
            first_ch_q  <= first_ch_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign first_ded_ch_o  = first_ch_q;
    assign first_ded_vld_o = first_vld_q;
`endif

endmodule

// File: tb/tb_cv32e40p_ecc_err_monitor.sv
// tb/tb_cv32e40p_ecc_err_monitor.sv - directed self-checking bench for cv32e40p_ecc_err_monitor
module tb_cv32e40p_ecc_err_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sec, ded;
    logic [1:0] rd_ch, clr_ch;
    logic       clr_ch_valid, clr_all;
    logic [8:0] rd_data;
    logic       degraded, fatal, irq, ded_any;
`ifdef CV32E40P_ECC_MON_FIRST_ERR_EN
    logic [1:0] first_ch;
    logic       first_vld;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e40p_ecc_err_monitor #(.NUM_CH(3), .CNT_W(8), .SEC_THRESH(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sec_i          (sec),
        .ded_i          (ded),
        .rd_ch_i        (rd_ch),
        .rd_data_o      (rd_data),
        .clr_ch_valid_i (clr_ch_valid),
        .clr_ch_i       (clr_ch),
        .clr_all_i      (clr_all),
`ifdef CV32E40P_ECC_MON_FIRST_ERR_EN
        .first_ded_ch_o (first_ch),
        .first_ded_vld_o(first_vld),
`endif
        .degraded_o     (degraded),
        .fatal_o        (fatal),
        .irq_o          (irq),
        .ded_any_o      (ded_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sec = '0; ded = '0; clr_ch_valid = 1'b0; clr_ch = '0; clr_all = 1'b0;
    endtask

    initial begin
        idle();
        rd_ch = '0;
        rst   = 1'b1;
        sec   = 3'b111; ded = 3'b101;
        step();
        sec   = 3'b010; ded = 3'b010;
        step();
        check("rst_degraded", degraded, 0);
        check("rst_fatal",    fatal,    0);
        check("rst_irq",      irq,      0);
        check("rst_ded_any",  ded_any,  0);
        check("rst_rd_data",  rd_data,  0);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            rd_ch = 2'(c);
            step();
            check($sformatf("rst_rd_ch%0d", c), rd_data, 0);
        end

        // threshold on channel 1
        rd_ch = 2'd1;
        sec   = 3'b010;
        for (int i = 0; i < 15; i++) step();
        check("thr15_degraded", degraded, 0);
        check("thr15_rd",       rd_data,  15);
        step();
        check("thr16_degraded", degraded, 1);
        check("thr16_irq",      irq,      1);
        check("thr16_rd",       rd_data,  9'h010);
        idle();
        step();
        check("thr_irq_once",   irq,      0);
        check("thr_hold_deg",   degraded, 1);

        // saturation on channel 0
        rd_ch = 2'd0;
        sec   = 3'b001;
        for (int i = 0; i < 300; i++) step();
        idle();
        step();
        check("sat_rd",  rd_data, 9'h0FF);
        check("sat_irq", irq,     0);

        // DED in DEGRADED
        ded = 3'b100;
        step();
        ded = '0;
        check("fat_fatal",    fatal,    1);
        check("fat_irq",      irq,      1);
        check("fat_ded_any",  ded_any,  1);
        check("fat_degraded", degraded, 0);
        step();
        check("fat_irq_once", irq,   0);
        check("fat_hold",     fatal, 1);
        rd_ch = 2'd2; clr_ch_valid = 1'b1; clr_ch = 2'd2;
        step();
        idle();
        check("fat_clrch_fatal",   fatal,   1);
        check("fat_clrch_rd",      rd_data, 0);
        check("fat_clrch_ded_any", ded_any, 0);
        clr_all = 1'b1;
        step();
        idle();
        check("clrall_fatal",    fatal,    0);
        check("clrall_degraded", degraded, 0);
        check("clrall_irq",      irq,      0);
        for (int c = 0; c < 3; c++) begin
            rd_ch = 2'(c);
            step();
            check($sformatf("clrall_rd_ch%0d", c), rd_data, 0);
        end

        // same-cycle sec + clear on channel 0
        rd_ch = 2'd0;
        sec   = 3'b001;
        for (int i = 0; i < 5; i++) step();
        check("coll_pre", rd_data, 5);
        clr_ch_valid = 1'b1; clr_ch = 2'd0;
        step();
        idle();
        check("coll_post", rd_data, 1);
        clr_ch_valid = 1'b1; clr_ch = 2'd3;
        step();
        idle();
        check("clr_oob_ignored", rd_data, 1);

        // DEGRADED returns to OK after a per-channel clear
        rd_ch = 2'd1;
        sec   = 3'b010;
        for (int i = 0; i < 16; i++) step();
        idle();
        check("deg2_degraded", degraded, 1);
        clr_ch_valid = 1'b1; clr_ch = 2'd1;
        step();
        idle();
        check("deg2_clr_ok",  degraded, 0);
        check("deg2_clr_irq", irq,      0);
        check("deg2_clr_rd",  rd_data,  0);

        // clr_all together with DED: OK -> FATAL, single irq
        rd_ch   = 2'd0;
        clr_all = 1'b1; ded = 3'b001;
        step();
        idle();
        check("clrded_fatal", fatal,   1);
        check("clrded_irq",   irq,     1);
        check("clrded_rd",    rd_data, 9'h100);
        step();
        check("clrded_irq_once", irq, 0);

`ifdef CV32E40P_ECC_MON_FIRST_ERR_EN
        clr_all = 1'b1;
        step();
        idle();
        check("first_cleared_vld", first_vld, 0);
        ded = 3'b110;
        step();
        ded = 3'b001;
        step();
        idle();
        check("first_ch",  first_ch,  1);
        check("first_vld", first_vld, 1);
`endif

        // reset mid-operation discards same-cycle inputs
        rst = 1'b1; sec = 3'b001; ded = 3'b010;
        step();
        rst = 1'b0;
        idle();
        check("midrst_rd",      rd_data,  0);
        check("midrst_fatal",   fatal,    0);
        check("midrst_ded_any", ded_any,  0);
        check("midrst_irq",     irq,      0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
